// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit and the datapath.
// The master side (control unit) consumes Run/opcode and drives every
// datapath control plus the debug/status outputs. The slave side is the
// datapath or a testbench.
interface multicycle_control_unit_if #(
    parameter int CNT_WIDTH = 16
);
    // Handshake and instruction input
    logic                 Run;
    logic [5:0]           opcode;

    // Datapath single-bit controls
    logic                 PC_write;
    logic                 Branch;
    logic                 Reg_write;
    logic                 Mem_to_reg;
    logic                 Reg_dst;
    logic                 IorD;
    logic                 Mem_write;
    logic                 IR_write;

    // Datapath mux selects and ALU operation
    logic [1:0]           PC_src;
    logic [1:0]           ALU_src_a;
    logic [1:0]           ALU_src_b;
    logic [3:0]           ALU_control;

    // Debug and status
    logic [3:0]           state_out;
    logic                 halted;
    logic                 illegal_op;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        input  Run, opcode,
        output PC_write, Branch, Reg_write, Mem_to_reg, Reg_dst, IorD,
               Mem_write, IR_write, PC_src, ALU_src_a, ALU_src_b,
               ALU_control, state_out, halted, illegal_op, instr_count
    );

    modport slave (
        output Run, opcode,
        input  PC_write, Branch, Reg_write, Mem_to_reg, Reg_dst, IorD,
               Mem_write, IR_write, PC_src, ALU_src_a, ALU_src_b,
               ALU_control, state_out, halted, illegal_op, instr_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle CPU datapath. Sequences
// fetch/decode/execute/memory/writeback one instruction at a time,
// tracks retired instructions, flags undefined opcodes and parks in HALT.
module multicycle_control_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    multicycle_control_unit_if.master      bus
);

    // Opcodes
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_SLT  = 6'h05;
    localparam logic [5:0] OP_NOR  = 6'h06;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h09;
    localparam logic [5:0] OP_ORI  = 6'h0A;
    localparam logic [5:0] OP_SLTI = 6'h0B;
    localparam logic [5:0] OP_LW   = 6'h10;
    localparam logic [5:0] OP_SW   = 6'h11;
    localparam logic [5:0] OP_BNE  = 6'h20;
    localparam logic [5:0] OP_J    = 6'h21;
    localparam logic [5:0] OP_HALT = 6'h3F;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    function automatic logic is_rtype(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_SLT) || (op == OP_NOR);
    endfunction

    function automatic logic is_itype(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) ||
               (op == OP_ORI)  || (op == OP_SLTI);
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // ANDI/ORI take the zero-extended immediate on ALU source B input 3.
    function automatic logic is_zext_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    // ALU operation for the R-type and I-type arithmetic/logic opcodes.
    function automatic logic [3:0] alu_for_op(input logic [5:0] op);
        logic [3:0] alu;
        case (op)
            OP_ADD, OP_ADDI: alu = ALU_ADD;
            OP_SUB:          alu = ALU_SUB;
            OP_AND, OP_ANDI: alu = ALU_AND;
            OP_OR,  OP_ORI:  alu = ALU_OR;
            OP_SLT, OP_SLTI: alu = ALU_SLT;
            OP_NOR:          alu = ALU_NOR;
            default:         alu = ALU_ADD;
        endcase
        return alu;
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   instr_count_q, instr_count_d;
    logic                   illegal_op_q, illegal_op_d;

    logic                   pc_write, branch, reg_write, mem_to_reg;
    logic                   reg_dst, iord, mem_write, ir_write, halted;
    logic [1:0]             pc_src, alu_src_a, alu_src_b;
    logic [3:0]             alu_control;

    // State, retired-instruction counter and sticky illegal flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            instr_count_q <= '0;
            illegal_op_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

    // Next-state selection; retire states count and sample Run here.
    always_comb begin
        logic retire;
        state_d       = state_q;
        instr_count_d = instr_count_q;
        illegal_op_d  = illegal_op_q;
        retire        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Run) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (is_rtype(bus.opcode)) begin
                    state_d = S_EXEC_R;
                end else if (is_itype(bus.opcode)) begin
                    state_d = S_EXEC_I;
                end else if (is_mem(bus.opcode)) begin
                    state_d = S_MEM_ADDR;
                end else if (bus.opcode == OP_BNE) begin
                    state_d = S_BRANCH;
                end else if (bus.opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (bus.opcode == OP_HALT) begin
                    // HALT counts as retired on entry, then never leaves.
                    state_d       = S_HALT;
                    instr_count_d = instr_count_q + CNT_ONE;
                end else begin
                    // Undefined opcode: abandon it without retiring.
                    illegal_op_d = 1'b1;
                    state_d      = bus.Run ? S_FETCH : S_IDLE;
                end
            end
            S_EXEC_R:   state_d = S_ALU_WB;
            S_EXEC_I:   state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP: retire = 1'b1;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_IDLE;
        endcase
        if (retire) begin
            instr_count_d = instr_count_q + CNT_ONE;
            state_d       = bus.Run ? S_FETCH : S_IDLE;
        end
    end

    // Moore outputs: datapath controls decoded from state (and opcode where the op matters).
    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        halted      = 1'b0;
        pc_src      = 2'd0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        alu_control = 4'b0000;
        case (state_q)
            S_FETCH: begin
                // Load IR and advance PC to PC+1 through the ALU.
                ir_write    = 1'b1;
                pc_write    = 1'b1;
                alu_src_a   = 2'd0;
                alu_src_b   = 2'd1;
                alu_control = ALU_ADD;
                pc_src      = 2'd0;
            end
            S_DECODE: begin
                // Speculatively form the branch target PC+1+simm.
                alu_src_a   = 2'd0;
                alu_src_b   = 2'd2;
                alu_control = ALU_ADD;
            end
            S_EXEC_R: begin
                alu_src_a   = 2'd1;
                alu_src_b   = 2'd0;
                alu_control = alu_for_op(bus.opcode);
            end
            S_EXEC_I: begin
                alu_src_a   = 2'd1;
                alu_src_b   = is_zext_imm(bus.opcode) ? 2'd3 : 2'd2;
                alu_control = alu_for_op(bus.opcode);
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b0;
                reg_dst    = is_rtype(bus.opcode);
            end
            S_MEM_ADDR: begin
                alu_src_a   = 2'd1;
                alu_src_b   = 2'd2;
                alu_control = ALU_ADD;
            end
            S_MEM_RD: begin
                iord = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                reg_dst    = 1'b0;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_BRANCH: begin
                // Datapath gates the PC load with the zero flag (rs != rt).
                alu_src_a   = 2'd1;
                alu_src_b   = 2'd0;
                alu_control = ALU_SUB;
                branch      = 1'b1;
                pc_src      = 2'd1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.PC_write    = pc_write;
    assign bus.Branch      = branch;
    assign bus.Reg_write   = reg_write;
    assign bus.Mem_to_reg  = mem_to_reg;
    assign bus.Reg_dst     = reg_dst;
    assign bus.IorD        = iord;
    assign bus.Mem_write   = mem_write;
    assign bus.IR_write    = ir_write;
    assign bus.PC_src      = pc_src;
    assign bus.ALU_src_a   = alu_src_a;
    assign bus.ALU_src_b   = alu_src_b;
    assign bus.ALU_control = alu_control;
    assign bus.state_out   = state_q;
    assign bus.halted      = halted;
    assign bus.illegal_op  = illegal_op_q;
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: directed scenarios plus a
// randomized instruction stream checked against a per-instruction model
// (state path by instruction class, control word per state, counter, flag).
module tb_multicycle_control_unit;

    logic clk;
    logic rst;

    multicycle_control_unit_if #(.CNT_WIDTH(16)) bus ();
    multicycle_control_unit_if #(.CNT_WIDTH(2))  bus2 ();

    multicycle_control_unit #(.CNT_WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multicycle_control_unit #(.CNT_WIDTH(2)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_count  = 0;
    bit m_illegal = 1'b0;
    int seq_q[$];

    // Instruction classes: 0 R, 1 I, 2 LW, 3 SW, 4 BNE, 5 J, 6 HALT, 7 illegal
    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06: return 0;
            6'h08, 6'h09, 6'h0A, 6'h0B:               return 1;
            6'h10: return 2;
            6'h11: return 3;
            6'h20: return 4;
            6'h21: return 5;
            6'h3F: return 6;
            default: return 7;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] op);
        case (op)
            6'h01, 6'h08: return 4'b0010;
            6'h02:        return 4'b0110;
            6'h03, 6'h09: return 4'b0000;
            6'h04, 6'h0A: return 4'b0001;
            6'h05, 6'h0B: return 4'b0111;
            6'h06:        return 4'b1100;
            default:      return 4'b0010;
        endcase
    endfunction

    // Expected control word {PC_write,Branch,Reg_write,Mem_to_reg,Reg_dst,IorD,
    // Mem_write,IR_write,PC_src,ALU_src_a,ALU_src_b,ALU_control,halted}
    function automatic logic [18:0] exp_ctrl(input int st, input logic [5:0] op);
        logic pcw = 0, br = 0, rw = 0, m2r = 0, rd = 0, iord = 0, mw = 0, irw = 0, hl = 0;
        logic [1:0] pcs = 0, sa = 0, sb = 0;
        logic [3:0] alu = 0;
        case (st)
            1:  begin irw = 1; pcw = 1; sb = 2'd1; alu = 4'b0010; end
            2:  begin sb = 2'd2; alu = 4'b0010; end
            3:  begin sa = 2'd1; alu = alu_of(op); end
            4:  begin sa = 2'd1; sb = (op == 6'h09 || op == 6'h0A) ? 2'd3 : 2'd2; alu = alu_of(op); end
            5:  begin rw = 1; rd = (op_class(op) == 0); end
            6:  begin sa = 2'd1; sb = 2'd2; alu = 4'b0010; end
            7:  begin iord = 1; end
            8:  begin rw = 1; m2r = 1; end
            9:  begin iord = 1; mw = 1; end
            10: begin sa = 2'd1; alu = 4'b0110; br = 1; pcs = 2'd1; end
            11: begin pcw = 1; pcs = 2'd2; end
            12: begin hl = 1; end
            default: begin end
        endcase
        return {pcw, br, rw, m2r, rd, iord, mw, irw, pcs, sa, sb, alu, hl};
    endfunction

    function automatic logic [18:0] act_ctrl();
        return {bus.PC_write, bus.Branch, bus.Reg_write, bus.Mem_to_reg, bus.Reg_dst,
                bus.IorD, bus.Mem_write, bus.IR_write, bus.PC_src, bus.ALU_src_a,
                bus.ALU_src_b, bus.ALU_control, bus.halted};
    endfunction

    // State path of one instruction, starting at FETCH, by class.
    task automatic fill_seq(input int cls);
        case (cls)
            0:       seq_q = '{1, 2, 3, 5};
            1:       seq_q = '{1, 2, 4, 5};
            2:       seq_q = '{1, 2, 6, 7, 8};
            3:       seq_q = '{1, 2, 6, 9};
            4:       seq_q = '{1, 2, 10};
            5:       seq_q = '{1, 2, 11};
            default: seq_q = '{1, 2};
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH. Run takes run_after at the final cycle
    // (or from index drop_at on); earlier cycles randomize Run if rand_mid.
    task automatic run_instr(input logic [5:0] op, input bit run_after,
                             input int drop_at, input bit rand_mid);
        int cls, last, nxt;
        cls = op_class(op);
        fill_seq(cls);
        last = seq_q.size() - 1;
        bus.opcode = op;
        for (int i = 0; i <= last; i++) begin
            n_checks++;
            if (bus.state_out !== 4'(seq_q[i])) begin
                n_fail++;
                $display("FAIL state op=%h idx=%0d got=%0d exp=%0d", op, i, bus.state_out, seq_q[i]);
            end
            n_checks++;
            if (act_ctrl() !== exp_ctrl(seq_q[i], op)) begin
                n_fail++;
                $display("FAIL ctrl op=%h st=%0d got=%h exp=%h", op, seq_q[i], act_ctrl(), exp_ctrl(seq_q[i], op));
            end
            n_checks++;
            if (bus.instr_count !== 16'(m_count)) begin
                n_fail++;
                $display("FAIL count op=%h st=%0d got=%0d exp=%0d", op, seq_q[i], bus.instr_count, m_count);
            end
            n_checks++;
            if (bus.illegal_op !== m_illegal) begin
                n_fail++;
                $display("FAIL illegal_flag op=%h st=%0d got=%b exp=%b", op, seq_q[i], bus.illegal_op, m_illegal);
            end
            if (i == last || i >= drop_at) bus.Run = run_after;
            else if (rand_mid) bus.Run = 1'($urandom_range(0, 1));
            step();
        end
        if (cls == 7) m_illegal = 1'b1;
        else m_count = (m_count + 1) % 65536;
        nxt = (cls == 6) ? 12 : (run_after ? 1 : 0);
        n_checks++;
        if (bus.state_out !== 4'(nxt)) begin
            n_fail++;
            $display("FAIL next_state op=%h got=%0d exp=%0d", op, bus.state_out, nxt);
        end
        n_checks++;
        if (bus.instr_count !== 16'(m_count)) begin
            n_fail++;
            $display("FAIL retire_count op=%h got=%0d exp=%0d", op, bus.instr_count, m_count);
        end
        n_checks++;
        if (bus.illegal_op !== m_illegal) begin
            n_fail++;
            $display("FAIL retire_illegal op=%h got=%b exp=%b", op, bus.illegal_op, m_illegal);
        end
    endtask

    // Hold IDLE with Run low for n cycles, then raise Run and expect FETCH.
    task automatic resume(input int n);
        bus.Run = 1'b0;
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (bus.state_out !== 4'd0 || act_ctrl() !== 19'd0) begin
                n_fail++;
                $display("FAIL idle_hold got_state=%0d got_ctrl=%h exp_state=0 exp_ctrl=0", bus.state_out, act_ctrl());
            end
            step();
        end
        bus.Run = 1'b1;
        step();
        n_checks++;
        if (bus.state_out !== 4'd1) begin
            n_fail++;
            $display("FAIL resume_fetch got=%0d exp=1", bus.state_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Run = 1'b0;   bus.opcode = 6'h00;
        bus2.Run = 1'b0;  bus2.opcode = 6'h00;
        repeat (2) step();
        n_checks++;
        if (bus.state_out !== 4'd0 || bus.instr_count !== 16'd0 || bus.illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state state=%0d count=%0d illegal=%b exp 0/0/0", bus.state_out, bus.instr_count, bus.illegal_op);
        end
        n_checks++;
        if (act_ctrl() !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%h exp=0", act_ctrl());
        end
        rst = 1'b0;
        m_count = 0;
        m_illegal = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (bus.state_out !== 4'd0 || act_ctrl() !== 19'd0) begin
                n_fail++;
                $display("FAIL run_low_idle state=%0d ctrl=%h exp state 0 ctrl 0", bus.state_out, act_ctrl());
            end
        end
    endtask

    task automatic test_rtype();
        bus.opcode = 6'h01;
        bus.Run = 1'b1;
        step();
        n_checks++;
        if (bus.state_out !== 4'd1) begin
            n_fail++;
            $display("FAIL idle_to_fetch got=%0d exp=1", bus.state_out);
        end
        run_instr(6'h01, 1'b1, 99, 1'b0);
    endtask

    task automatic test_mem();
        run_instr(6'h10, 1'b1, 99, 1'b0);
        run_instr(6'h11, 1'b1, 99, 1'b0);
    endtask

    task automatic test_itype_branch_jump();
        run_instr(6'h09, 1'b1, 99, 1'b0);
        run_instr(6'h20, 1'b1, 99, 1'b0);
        run_instr(6'h21, 1'b1, 99, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr(6'h2A, 1'b1, 99, 1'b0);
        run_instr(6'h01, 1'b1, 99, 1'b0);
        run_instr(6'h08, 1'b1, 99, 1'b0);
    endtask

    task automatic test_run_drop();
        run_instr(6'h01, 1'b0, 2, 1'b0);
        resume(3);
    endtask

    task automatic test_random();
        logic [5:0] legal_ops[16] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h08, 6'h09,
                                       6'h0A, 6'h0B, 6'h10, 6'h11, 6'h20, 6'h21, 6'h01, 6'h10};
        logic [5:0] bad_ops[6] = '{6'h00, 6'h07, 6'h0C, 6'h12, 6'h2A, 6'h3E};
        logic [5:0] op;
        bit ra;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) op = bad_ops[$urandom_range(0, 5)];
            else op = legal_ops[$urandom_range(0, 15)];
            ra = ($urandom_range(0, 3) != 0);
            run_instr(op, ra, 99, 1'b1);
            if (!ra) resume($urandom_range(1, 3));
        end
    endtask

    task automatic test_halt();
        run_instr(6'h3F, 1'b1, 99, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.Run = 1'($urandom_range(0, 1));
            step();
            n_checks++;
            if (bus.state_out !== 4'd12 || bus.halted !== 1'b1 || bus.instr_count !== 16'(m_count)) begin
                n_fail++;
                $display("FAIL halt_hold state=%0d halted=%b count=%0d exp 12/1/%0d", bus.state_out, bus.halted, bus.instr_count, m_count);
            end
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.state_out !== 4'd0 || bus.instr_count !== 16'd0 || bus.illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset state=%0d count=%0d illegal=%b exp 0/0/0", bus.state_out, bus.instr_count, bus.illegal_op);
        end
        n_checks++;
        if (act_ctrl() !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset_ctrl got=%h exp=0", act_ctrl());
        end
        bus.Run = 1'b0;
        step();
        rst = 1'b0;
        m_count = 0;
        m_illegal = 1'b0;
    endtask

    task automatic test_wrap();
        bus2.opcode = 6'h21;
        bus2.Run = 1'b1;
        step();
        n_checks++;
        if (bus2.state_out !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_fetch got=%0d exp=1", bus2.state_out);
        end
        for (int k = 0; k < 4; k++) begin
            repeat (3) step();
            n_checks++;
            if (bus2.instr_count !== 2'((k + 1) % 4) || bus2.state_out !== 4'd1) begin
                n_fail++;
                $display("FAIL wrap_count k=%0d got=%0d state=%0d exp=%0d state 1", k, bus2.instr_count, bus2.state_out, (k + 1) % 4);
            end
        end
        bus2.Run = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_mem();
        test_itype_branch_jump();
        test_illegal();
        test_run_drop();
        test_random();
        test_halt();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
